display_write_arbiter: RTL and testbench
========================================

Name: display_write_arbiter

Overview:
- Sole owner of the block-colour display write port (we + 14-bit {color[2:0], x[5:0], y[4:0]}).
- Shares that port between CPU display stores and a hardware screen-clear engine.
- CPU stores are buffered in a small FIFO. A clear sweeps all 40x30 blocks with one colour, one block per cycle.
- Program order between CPU stores and clear requests is preserved.

Parameters:
- FIFO_DEPTH, 4, CPU store buffer entries; power of two, >= 2.
- GRID_W, 40, blocks per row (x range 0..GRID_W-1).
- GRID_H, 30, rows (y range 0..GRID_H-1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_we  in  1  CPU display store strobe, one store per cycle
- cpu_data  in  14  {color[13:11], x[10:5], y[4:0]}
- cpu_ready  out  1  store accepted this cycle if cpu_we=1
- clr_req  in  1  single-cycle request to start a clear
- clr_color  in  3  fill colour, sampled with an accepted clr_req
- clr_busy  out  1  clear pending or in progress
- disp_we  out  1  write strobe to display RAM
- disp_data  out  14  write word to display RAM, same packing as cpu_data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- err_drop  out  1  sticky: a store was dropped

Behaviour:
- Reset (rst_n low, async): state IDLE, FIFO flushed, x/y counters 0, disp_we=0, disp_data=0, clr_busy=0, err_drop=0, fifo_level=0. cpu_ready reads 1 while in reset.
- Reset asserted mid-clear or mid-drain aborts immediately; buffered stores are lost.
- disp_we and disp_data are registered. At most one display write per cycle.
- cpu_ready = !full && state != DRAIN (combinational).
  - Push occurs when cpu_we && cpu_ready.
  - cpu_we && !cpu_ready: store dropped, err_drop set; it stays set until reset.
- FSM:
  - IDLE:
    - If FIFO non-empty, pop head; disp_we=1 next cycle with that word.
    - Store into an empty FIFO: disp_we in the 2nd cycle after the sampling edge.
    - On clr_req: latch clr_color, clr_busy=1. Go to CLEAR if FIFO empty after this cycle's pop and no push this cycle, else DRAIN.
    - A cpu_we in the same cycle as clr_req is pushed first, so it precedes the clear.
  - DRAIN:
    - Pushes refused (cpu_ready=0); pops continue one per cycle.
    - When the last entry is popped, go to CLEAR next cycle.
  - CLEAR:
    - Each cycle: disp_we=1, disp_data={clr_color_latched, x, y}.
    - Order: y outer 0..GRID_H-1, x inner 0..GRID_W-1. Start (0,0), end (GRID_W-1,GRID_H-1): 1200 writes in 1200 consecutive cycles.
    - x wraps to 0 and y increments after GRID_W-1.
    - CPU pushes are accepted while not full; no pops.
    - After the final write, clr_busy=0 and return to IDLE. FIFO drain resumes the next cycle.
- clr_req while clr_busy=1: ignored, no queuing.
- Push and pop in the same cycle: both occur; level unchanged.
- fifo_level updates on the edge after push/pop.
- Counters: x is 6 bits, y is 5 bits. No arithmetic on the packed address; address formation stays in the display.

Optional Feature:
- Macro DISPLAY_COORD_CHECK_EN.
- Defined: on push, a store with x >= GRID_W or y >= GRID_H is discarded (not written to FIFO, cpu_ready unaffected) and sets err_drop.
- Undefined: stores pass through unchecked. Out-of-range coordinates alias in the display RAM; err_drop reflects only FIFO-full drops.

Test Plan:
- Reset, then cpu_we=1, cpu_data={3'b101,6'd5,5'd7} -> disp_we=1, disp_data=14'h28A7 two cycles later; fifo_level returns to 0.
- clr_req with clr_color=3'b010, FIFO empty -> 1200 consecutive disp_we cycles; first word {010,0,0}, 41st word {010,0,1}, last {010,39,29}; clr_busy deasserts after the last.
- Push 3 stores, then clr_req next cycle -> 3 stores drained in order, cpu_ready=0 during DRAIN, then the clear starts.
- During CLEAR push FIFO_DEPTH+1 stores -> first 4 accepted, 5th dropped with cpu_ready=0, err_drop=1; the 4 appear in order right after the clear ends.
- Assert rst_n=0 at clear write 600 -> disp_we=0, clr_busy=0, fifo_level=0 immediately; no further writes after release.
- DISPLAY_COORD_CHECK_EN defined: push x=40,y=0 -> no disp_we, err_drop=1. Undefined: written through unchanged.

Source files
------------

// File: rtl/display_write_if.sv
// Bus bundle between the display write arbiter and its CPU / clear / display-RAM neighbours.
// The arbiter owns the slave side; the CPU-facing stimulus owns the master side.

interface display_write_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          cpu_we;
    logic [13:0]   cpu_data;
    logic          cpu_ready;
    logic          clr_req;
    logic [2:0]    clr_color;
    logic          clr_busy;
    logic          disp_we;
    logic [13:0]   disp_data;
    logic [LW-1:0] fifo_level;
    logic          err_drop;

    modport master (
        output cpu_we,
        output cpu_data,
        output clr_req,
        output clr_color,
        input  cpu_ready,
        input  clr_busy,
        input  disp_we,
        input  disp_data,
        input  fifo_level,
        input  err_drop
    );

    modport slave (
        input  cpu_we,
        input  cpu_data,
        input  clr_req,
        input  clr_color,
        output cpu_ready,
        output clr_busy,
        output disp_we,
        output disp_data,
        output fifo_level,
        output err_drop
    );
endinterface

// File: rtl/display_write_arbiter.sv
// Sole owner of the block-colour display write port: drains buffered CPU stores and runs the
// full-screen clear sweep. Optional macro DISPLAY_COORD_CHECK_EN discards out-of-grid stores.

module display_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30
) (
    input  logic           clk,
    input  logic           rst_n,
    display_write_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [5:0]    X_LAST_C = 6'(GRID_W - 1);
    localparam logic [4:0]    Y_LAST_C = 5'(GRID_H - 1);
    localparam logic [LW-1:0] FULL_C   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] ONE_C    = LW'(1'b1);
    localparam logic [LW-1:0] ZERO_C   = {LW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [13:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  count_r;

    logic [5:0]     x_r;
    logic [5:0]     x_s;
    logic [4:0]     y_r;
    logic [4:0]     y_s;
    logic [2:0]     clr_color_r;
    logic [2:0]     clr_color_s;

    logic           disp_we_r;
    logic           disp_we_s;
    logic [13:0]    disp_data_r;
    logic [13:0]    disp_data_s;
    logic           clr_busy_r;
    logic           err_drop_r;

    logic           full_s;
    logic           empty_s;
    logic           cpu_ready_s;
    logic           coord_bad_s;
    logic           push_s;
    logic           drop_s;
    logic           pop_s;

    // FIFO status and the accept / drop decision for the incoming CPU store.
    always_comb begin
        full_s      = (count_r == FULL_C);
        empty_s     = (count_r == ZERO_C);
        cpu_ready_s = !full_s && (state_r != DRAIN);
`ifdef DISPLAY_COORD_CHECK_EN
        coord_bad_s = (bus.cpu_data[10:5] > X_LAST_C) || (bus.cpu_data[4:0] > Y_LAST_C);
`else
        coord_bad_s = 1'b0;
`endif
        push_s = bus.cpu_we && cpu_ready_s && !coord_bad_s;
        drop_s = bus.cpu_we && (!cpu_ready_s || coord_bad_s);
    end

    // Next-state, pop and display-write selection.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        disp_we_s   = 1'b0;
        disp_data_s = disp_data_r;
        x_s         = x_r;
        y_s         = y_r;
        clr_color_s = clr_color_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    disp_we_s   = 1'b1;
                    disp_data_s = mem_r[rd_ptr_r];
                end else begin
                    pop_s       = 1'b0;
                end
                // The FIFO is empty after this edge only if at most one entry is popped and none pushed.
                if (bus.clr_req) begin
                    clr_color_s = bus.clr_color;
                    if (!push_s && (count_r <= ONE_C)) begin
                        state_s = CLEAR;
                    end else begin
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    disp_we_s   = 1'b1;
                    disp_data_s = mem_r[rd_ptr_r];
                    if (count_r == ONE_C) begin
                        state_s = CLEAR;
                    end else begin
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = CLEAR;
                end
            end
            CLEAR: begin
                disp_we_s   = 1'b1;
                disp_data_s = {clr_color_r, x_r, y_r};
                if (x_r == X_LAST_C) begin
                    x_s = 6'd0;
                    if (y_r == Y_LAST_C) begin
                        y_s     = 5'd0;
                        state_s = IDLE;
                    end else begin
                        y_s     = y_r + 5'd1;
                        state_s = CLEAR;
                    end
                end else begin
                    x_s     = x_r + 6'd1;
                    y_s     = y_r;
                    state_s = CLEAR;
                end
            end
            default: begin
                state_s = IDLE;
                x_s     = 6'd0;
                y_s     = 5'd0;
            end
        endcase
    end

    // FSM state, sweep counters, latched colour and registered display/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            x_r         <= 6'd0;
            y_r         <= 5'd0;
            clr_color_r <= 3'd0;
            disp_we_r   <= 1'b0;
            disp_data_r <= 14'd0;
            clr_busy_r  <= 1'b0;
            err_drop_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            clr_color_r <= clr_color_s;
            disp_we_r   <= disp_we_s;
            disp_data_r <= disp_data_s;
            clr_busy_r  <= (state_s != IDLE);
            err_drop_r  <= err_drop_r || drop_s;
        end
    end

    // CPU store buffer: circular storage with pointers that wrap on the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 14'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.cpu_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + LW'(push_s) - LW'(pop_s);
        end
    end

    assign bus.cpu_ready  = cpu_ready_s;
    assign bus.clr_busy   = clr_busy_r;
    assign bus.disp_we    = disp_we_r;
    assign bus.disp_data  = disp_data_r;
    assign bus.fifo_level = count_r;
    assign bus.err_drop   = err_drop_r;

endmodule

// File: tb/tb_display_write_arbiter.sv
// Randomized and directed bench for display_write_arbiter against a queue/index reference model.
// Honours DISPLAY_COORD_CHECK_EN in the model when the macro is defined.

module tb_display_write_arbiter;
    localparam int FIFO_DEPTH = 4;
    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int M_IDLE     = 0;
    localparam int M_DRAIN    = 1;
    localparam int M_CLEAR    = 2;
`ifdef DISPLAY_COORD_CHECK_EN
    localparam bit COORD_CHECK = 1'b1;
`else
    localparam bit COORD_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    display_write_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus_if ();

    display_write_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [13:0] mq[$];
    int          m_mode;
    int          m_idx;
    logic [2:0]  m_col;
    bit          m_err;
    bit          m_we;
    logic [13:0] m_word;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (mq.size() < FIFO_DEPTH) && (m_mode != M_DRAIN);
    endfunction

    function automatic bit coord_bad(input logic [13:0] d);
        return COORD_CHECK && ((int'(d[10:5]) >= GRID_W) || (int'(d[4:0]) >= GRID_H));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = M_IDLE;
        m_idx  = 0;
        m_col  = 3'd0;
        m_err  = 1'b0;
        m_we   = 1'b0;
        m_word = 14'd0;
    endtask

    task automatic model_step(input bit we, input logic [13:0] d, input bit cr, input logic [2:0] cc);
        bit rdy;
        int mode_q;
        rdy    = m_ready();
        mode_q = m_mode;
        m_we   = 1'b0;
        if (mode_q == M_CLEAR) begin
            m_we   = 1'b1;
            m_word = {m_col, 6'(m_idx % GRID_W), 5'(m_idx / GRID_W)};
            m_idx++;
            if (m_idx == GRID_W * GRID_H) begin
                m_idx  = 0;
                m_mode = M_IDLE;
            end
        end else if (mq.size() > 0) begin
            m_we   = 1'b1;
            m_word = mq.pop_front();
        end
        if (we) begin
            if (!rdy || coord_bad(d)) m_err = 1'b1;
            else mq.push_back(d);
        end
        if (mode_q == M_IDLE && cr) begin
            m_col  = cc;
            m_mode = (mq.size() == 0) ? M_CLEAR : M_DRAIN;
        end else if (mode_q == M_DRAIN && mq.size() == 0) begin
            m_mode = M_CLEAR;
        end
    endtask

    // one clock: drive at negedge, step model at posedge, compare at next negedge
    task automatic cycle(input bit we, input logic [13:0] d, input bit cr, input logic [2:0] cc);
        bus_if.cpu_we    = we;
        bus_if.cpu_data  = d;
        bus_if.clr_req   = cr;
        bus_if.clr_color = cc;
        #1;
        check_val("cpu_ready", 32'(bus_if.cpu_ready), 32'(m_ready()));
        @(posedge clk);
        model_step(we, d, cr, cc);
        @(negedge clk);
        check_val("disp_we", 32'(bus_if.disp_we), 32'(m_we));
        if (m_we) check_val("disp_data", 32'(bus_if.disp_data), 32'(m_word));
        check_val("clr_busy", 32'(bus_if.clr_busy), 32'(m_mode != M_IDLE));
        check_val("fifo_level", 32'(bus_if.fifo_level), 32'(mq.size()));
        check_val("err_drop", 32'(bus_if.err_drop), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 14'd0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        bus_if.cpu_we  = 1'b0;
        bus_if.clr_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_disp_we", 32'(bus_if.disp_we), 32'd0);
        check_val("rst_disp_data", 32'(bus_if.disp_data), 32'd0);
        check_val("rst_clr_busy", 32'(bus_if.clr_busy), 32'd0);
        check_val("rst_level", 32'(bus_if.fifo_level), 32'd0);
        check_val("rst_err_drop", 32'(bus_if.err_drop), 32'd0);
        check_val("rst_cpu_ready", 32'(bus_if.cpu_ready), 32'd1);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nw;
        logic [13:0] d;
        rst_n            = 1'b1;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_data  = 14'd0;
        bus_if.clr_req   = 1'b0;
        bus_if.clr_color = 3'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single store reaches the display two cycles after it is sampled
        cycle(1'b1, {3'b101, 6'd5, 5'd7}, 1'b0, 3'd0);
        cycle(1'b0, 14'd0, 1'b0, 3'd0);
        check_val("store_we", 32'(bus_if.disp_we), 32'd1);
        check_val("store_word", 32'(bus_if.disp_data), 32'h28A7);
        idle(2);

        // full clear from an empty FIFO
        cycle(1'b0, 14'd0, 1'b1, 3'b010);
        nw = 0;
        for (int i = 0; i < 1205; i++) begin
            cycle(1'b0, 14'd0, 1'b0, 3'd0);
            if (bus_if.disp_we) begin
                nw++;
                if (nw == 1)    check_val("clr_first", 32'(bus_if.disp_data), 32'h1000);
                if (nw == 41)   check_val("clr_41st", 32'(bus_if.disp_data), 32'h1001);
                if (nw == 1200) check_val("clr_last", 32'(bus_if.disp_data), 32'h14FD);
            end
        end
        check_val("clr_count", 32'(nw), 32'd1200);

        // three stores then a clear request: drain in order, then sweep
        cycle(1'b1, {3'd1, 6'd1, 5'd1}, 1'b0, 3'd0);
        cycle(1'b1, {3'd2, 6'd2, 5'd2}, 1'b0, 3'd0);
        cycle(1'b1, {3'd3, 6'd3, 5'd3}, 1'b0, 3'd0);
        cycle(1'b0, 14'd0, 1'b1, 3'b110);
        idle(1210);

        // overfill the FIFO during a clear
        cycle(1'b0, 14'd0, 1'b1, 3'b001);
        idle(10);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) cycle(1'b1, {3'(i), 6'(i + 10), 5'(i + 3)}, 1'b0, 3'd0);
        check_val("overflow_err", 32'(bus_if.err_drop), 32'd1);
        idle(1200);

        // reset in the middle of a sweep, with a store buffered
        do_reset();
        cycle(1'b0, 14'd0, 1'b1, 3'b111);
        cycle(1'b1, {3'd4, 6'd20, 5'd20}, 1'b0, 3'd0);
        idle(599);
        do_reset();
        idle(20);

        // out-of-grid coordinate
        cycle(1'b1, {3'b001, 6'd40, 5'd0}, 1'b0, 3'd0);
        idle(3);
        check_val("coord_err", 32'(bus_if.err_drop), 32'(COORD_CHECK));
        do_reset();

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            d = {3'($urandom_range(0, 7)), 6'($urandom_range(0, GRID_W + 1)), 5'($urandom_range(0, GRID_H))};
            cycle(($urandom_range(0, 99) < 45), d, ($urandom_range(0, 299) == 0), 3'($urandom_range(0, 7)));
        end
        idle(1300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
